tile_console_writer: RTL and testbench
======================================

TILE_CONSOLE_WRITER -- requirements
Module: tile_console_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, tiles per row.
REQ-002 SHALL have parameter ROWS, default 60, tile rows.
REQ-003 SHALL have parameter BLANK, default 8'h20, tile code written when clearing.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  character offered.
REQ-007 SHALL have port in_data  input  8  character/control code.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port addr  output  13  tile RAM write address (row*COLS+col).
REQ-010 SHALL have port dina  output  8  tile RAM write data.
REQ-011 SHALL have port wea  output  1  tile RAM write enable, one write per asserted cycle.
REQ-012 SHALL have port cursor_x  output  7  current column, 0..COLS-1.
REQ-013 SHALL have port cursor_y  output  6  current row, 0..ROWS-1.
REQ-014 SHALL have port busy  output  1  high while in CLEAR or LINE_CLEAR.

Function
REQ-015 SHALL implement states IDLE, CLEAR, LINE_CLEAR; in_ready = (state==IDLE).
REQ-016 Transfer SHALL occur on a clk edge with in_valid && in_ready; no other edge consumes data.
REQ-017 addr, dina, wea SHALL be registered; a write caused by a transfer SHALL appear the cycle after it, for exactly one cycle.
REQ-018 Printable 8'h20..8'h7E: write code at (cursor_x,cursor_y); cursor_x+1.
REQ-019 Printable at cursor_x==COLS-1: write, then cursor_x=0, cursor_y advance, enter LINE_CLEAR.
REQ-020 8'h0A (LF): no write; cursor_x=0, cursor_y advance, enter LINE_CLEAR.
REQ-021 8'h0D (CR): no write; cursor_x=0.
REQ-022 8'h08 (BS): if cursor_x>0, cursor_x-1 and write BLANK at the new position; if cursor_x==0, no write, no cursor change.
REQ-023 8'h0C (FF): cursor to (0,0); enter CLEAR.
REQ-024 All other codes SHALL be consumed with no write and no cursor change.
REQ-025 Row advance SHALL wrap: cursor_y==ROWS-1 goes to 0; no scrolling.
REQ-026 LINE_CLEAR SHALL write BLANK to the new row's COLS addresses in ascending order, one per cycle, then return to IDLE.
REQ-027 CLEAR SHALL write BLANK to addresses 0..COLS*ROWS-1 (4799 default) ascending, one per cycle, then return to IDLE.
REQ-028 Address SHALL equal row*COLS+col; with default COLS, computed as (row<<6)+(row<<4)+col, no multiplier.
REQ-029 wea SHALL never assert with addr >= COLS*ROWS.

Reset
REQ-030 On clr: cursor (0,0), wea=0, addr=0, dina=BLANK, in_ready=0, busy=1, state=CLEAR with fill counter 0.
REQ-031 clr asserted mid-CLEAR or mid-LINE_CLEAR SHALL abort and restart full CLEAR from address 0.
REQ-032 After reset, in_ready SHALL rise only after the last CLEAR write (COLS*ROWS write cycles).

Structure
REQ-033 Shared package SHALL hold state encoding, control codes (LF, CR, BS, FF), BLANK default, and COLS*ROWS depth constant.
REQ-034 A single sub-module tile_addr_calc (row, col -> 13-bit addr) SHALL be used; no other sub-modules.
REQ-035 Outputs SHALL connect directly to the tile RAM write port (addra, dina, wea) with no glue logic.

Verification
REQ-036 Reset then idle: exactly 4800 wea cycles, addr 0..4799, dina 8'h20, then in_ready=1, busy=0.
REQ-037 Send 8'h41 after init: next cycle wea=1, addr=0, dina=8'h41; cursor_x=1.
REQ-038 Send 80 printables on row 0: last writes addr 79; then LINE_CLEAR writes 80..159 with 8'h20; next char lands at addr 80.
REQ-039 Cursor on row 59, send 8'h0A: cursor_y=0; writes addr 0..79 with 8'h20; in_ready low for 80 cycles.
REQ-040 BS at cursor_x=0: no wea, cursor unchanged; BS at cursor_x=5, row 2: write 8'h20 at addr 164, cursor_x=4.
REQ-041 Assert clr during CLEAR at fill address 2000: next write is addr 0; full 4800-write sequence repeats.

Source files
------------

// File: rtl/tile_console_writer_pkg.sv
// rtl/tile_console_writer_pkg.sv - shared states, control codes and geometry for the tile console writer
package tile_console_writer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CLEAR      = 2'd1,
        LINE_CLEAR = 2'd2
    } state_t;

    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_FF = 8'h0C;

    localparam logic [7:0] BLANK_DEFAULT = 8'h20;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 60;
    localparam int TILE_DEPTH   = DEFAULT_COLS * DEFAULT_ROWS;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/tile_console_writer_addr_calc.sv
// rtl/tile_console_writer_addr_calc.sv - tile_addr_calc: row/column to linear tile RAM address
module tile_addr_calc #(
    parameter int COLS = 80
) (
    input  logic [5:0]  row,
    input  logic [6:0]  col,
    output logic [12:0] addr
);

    generate
        if (COLS == 80) begin : g_shift
            // 80 = 64 + 16, so two shifted copies of the row replace a multiplier
            assign addr = {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {6'b0, col};
        end else begin : g_mult
            assign addr = 13'(int'(row) * COLS + int'(col));
        end
    endgenerate

endmodule

// File: rtl/tile_console_writer.sv
// rtl/tile_console_writer.sv - character stream to tile RAM writer with cursor, line clear and screen clear
module tile_console_writer
    import tile_console_writer_pkg::*;
#(
    parameter int         COLS  = DEFAULT_COLS,
    parameter int         ROWS  = DEFAULT_ROWS,
    parameter logic [7:0] BLANK = BLANK_DEFAULT
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [12:0] addr,
    output logic [7:0]  dina,
    output logic        wea,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);

    localparam int          DEPTH     = COLS * ROWS;
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
    localparam logic [12:0] LAST_FILL = 13'(DEPTH - 1);
    localparam logic [12:0] LAST_LINE = 13'(COLS - 1);

    state_t      state, state_n;
    logic [12:0] fill, fill_n;
    logic [6:0]  cx_n;
    logic [5:0]  cy_n;
    logic [5:0]  cy_adv;
    logic        wea_n;
    logic [12:0] addr_n;
    logic [7:0]  dina_n;
    logic [6:0]  calc_col;
    logic [12:0] calc_addr;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign cy_adv   = (cursor_y == LAST_ROW) ? 6'd0 : cursor_y + 6'd1;

    // During LINE_CLEAR cursor_y already points at the row being blanked
    assign calc_col = (state == LINE_CLEAR) ? fill[6:0] :
                      (in_data == CODE_BS)  ? cursor_x - 7'd1 : cursor_x;

    tile_addr_calc #(.COLS(COLS)) u_addr_calc (
        .row  (cursor_y),
        .col  (calc_col),
        .addr (calc_addr)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= CLEAR;
            fill     <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            wea      <= 1'b0;
            addr     <= '0;
            dina     <= BLANK;
        end else begin
            state    <= state_n;
            fill     <= fill_n;
            cursor_x <= cx_n;
            cursor_y <= cy_n;
            wea      <= wea_n;
            addr     <= addr_n;
            dina     <= dina_n;
        end
    end

    always_comb begin
        state_n = state;
        fill_n  = fill;
        cx_n    = cursor_x;
        cy_n    = cursor_y;
        wea_n   = 1'b0;
        addr_n  = addr;
        dina_n  = dina;
        case (state)
            CLEAR: begin
                wea_n  = 1'b1;
                addr_n = fill;
                dina_n = BLANK;
                fill_n = fill + 13'd1;
                if (fill == LAST_FILL) begin
                    state_n = IDLE;
                    fill_n  = '0;
                end
            end
            LINE_CLEAR: begin
                wea_n  = 1'b1;
                addr_n = calc_addr;
                dina_n = BLANK;
                fill_n = fill + 13'd1;
                if (fill == LAST_LINE) begin
                    state_n = IDLE;
                    fill_n  = '0;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    if (is_printable(in_data)) begin
                        wea_n  = 1'b1;
                        addr_n = calc_addr;
                        dina_n = in_data;
                        if (cursor_x == LAST_COL) begin
                            cx_n    = '0;
                            cy_n    = cy_adv;
                            state_n = LINE_CLEAR;
                            fill_n  = '0;
                        end else begin
                            cx_n = cursor_x + 7'd1;
                        end
                    end else begin
                        case (in_data)
                            CODE_LF: begin
                                cx_n    = '0;
                                cy_n    = cy_adv;
                                state_n = LINE_CLEAR;
                                fill_n  = '0;
                            end
                            CODE_CR: cx_n = '0;
                            CODE_BS: begin
                                if (cursor_x != 7'd0) begin
                                    cx_n   = cursor_x - 7'd1;
                                    wea_n  = 1'b1;
                                    addr_n = calc_addr;
                                    dina_n = BLANK;
                                end
                            end
                            CODE_FF: begin
                                cx_n    = '0;
                                cy_n    = '0;
                                state_n = CLEAR;
                                fill_n  = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                state_n = CLEAR;
                fill_n  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tile_console_writer.sv
// tb/tb_tile_console_writer.sv - directed self-checking bench for tile_console_writer
module tb_tile_console_writer;

    logic        clk = 1'b0;
    logic        clr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [12:0] addr;
    logic [7:0]  dina;
    logic        wea;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int oob      = 0;

    tile_console_writer dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .addr     (addr),
        .dina     (dina),
        .wea      (wea),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wea && addr >= 13'd4800) oob++;

    typedef struct {
        logic [7:0]  code;
        logic        wea;
        logic [12:0] addr;
        logic [7:0]  dina;
        logic [6:0]  cx;
        logic [5:0]  cy;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where the transfer's result is visible
    task automatic send(input logic [7:0] d);
        int n = 0;
        while (!in_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_fill(input int start, output int nw, output int nbad, output int nlow);
        nw = 0; nbad = 0; nlow = 0;
        for (int i = 0; i < 6000; i++) begin
            if (wea) begin
                if (addr != 13'(start + nw) || dina != 8'h20) nbad++;
                nw++;
            end
            if (in_ready) break;
            nlow++;
            @(negedge clk);
        end
        if (!in_ready) chk("fill_timeout", 0, 1);
    endtask

    initial begin
        int nw, nbad, nlow, bad, n;

        vecs[0] = '{8'h41, 1'b1, 13'd0, 8'h41, 7'd1, 6'd0};
        vecs[1] = '{8'h42, 1'b1, 13'd1, 8'h42, 7'd2, 6'd0};
        vecs[2] = '{8'h01, 1'b0, 13'd0, 8'h00, 7'd2, 6'd0};
        vecs[3] = '{8'h08, 1'b1, 13'd1, 8'h20, 7'd1, 6'd0};
        vecs[4] = '{8'h0D, 1'b0, 13'd0, 8'h00, 7'd0, 6'd0};
        vecs[5] = '{8'h08, 1'b0, 13'd0, 8'h00, 7'd0, 6'd0};
        vecs[6] = '{8'h43, 1'b1, 13'd0, 8'h43, 7'd1, 6'd0};
        vecs[7] = '{8'h7E, 1'b1, 13'd1, 8'h7E, 7'd2, 6'd0};
        vecs[8] = '{8'h7F, 1'b0, 13'd0, 8'h00, 7'd2, 6'd0};
        vecs[9] = '{8'h1F, 1'b0, 13'd0, 8'h00, 7'd2, 6'd0};

        clr = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wea", wea, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dina", dina, 8'h20);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_cursor", {cursor_y, cursor_x}, 0);

        clr = 1'b0;
        run_fill(0, nw, nbad, nlow);
        chk("init_writes", nw, 4800);
        chk("init_bad", nbad, 0);
        chk("init_low_cycles", nlow, 4800);
        @(negedge clk);
        chk("init_ready", in_ready, 1);
        chk("init_busy", busy, 0);

        foreach (vecs[i]) begin
            send(vecs[i].code);
            chk($sformatf("vec%0d_wea", i), wea, vecs[i].wea);
            if (vecs[i].wea) begin
                chk($sformatf("vec%0d_addr", i), addr, vecs[i].addr);
                chk($sformatf("vec%0d_dina", i), dina, vecs[i].dina);
            end
            chk($sformatf("vec%0d_cx", i), cursor_x, vecs[i].cx);
            chk($sformatf("vec%0d_cy", i), cursor_y, vecs[i].cy);
        end

        // Form feed clears the screen and homes the cursor
        send(8'h0C);
        chk("ff_cursor", {cursor_y, cursor_x}, 0);
        chk("ff_busy", busy, 1);
        run_fill(0, nw, nbad, nlow);
        chk("ff_writes", nw, 4800);
        chk("ff_bad", nbad, 0);

        // Full row of printables, wrap into a line clear of row 1
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            send(8'h30 + 8'(i % 40));
            if (!wea || addr != 13'(i) || dina != 8'h30 + 8'(i % 40)) bad++;
        end
        chk("row0_bad", bad, 0);
        chk("row0_last_addr", addr, 79);
        chk("row0_wrap_cursor", {cursor_y, cursor_x}, {6'd1, 7'd0});
        chk("row0_wrap_busy", busy, 1);
        @(negedge clk);
        run_fill(80, nw, nbad, nlow);
        chk("lc1_writes", nw, 80);
        chk("lc1_bad", nbad, 0);
        chk("lc1_low", nlow, 79);
        @(negedge clk);
        send(8'h5A);
        chk("row1_first_addr", addr, 80);
        chk("row1_first_dina", dina, 8'h5A);
        chk("row1_cursor", {cursor_y, cursor_x}, {6'd1, 7'd1});

        // Walk down to the last row, then wrap back to row 0
        send(8'h0D);
        bad = 0;
        for (int r = 1; r < 59; r++) begin
            send(8'h0A);
            run_fill((r + 1) * 80, nw, nbad, nlow);
            if (nw != 80 || nbad != 0) bad++;
        end
        chk("lf_rows_bad", bad, 0);
        @(negedge clk);
        chk("at_last_row", cursor_y, 59);
        send(8'h0A);
        chk("wrap_wea", wea, 0);
        chk("wrap_cursor", {cursor_y, cursor_x}, 0);
        run_fill(0, nw, nbad, nlow);
        chk("wrap_writes", nw, 80);
        chk("wrap_bad", nbad, 0);
        chk("wrap_low", nlow, 80);

        // Backspace at column 5 of row 2
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            send(8'h0A);
            run_fill((k + 1) * 80, nw, nbad, nlow);
        end
        @(negedge clk);
        for (int k = 0; k < 5; k++) send(8'h61);
        chk("pre_bs_cx", cursor_x, 5);
        send(8'h08);
        chk("bs_wea", wea, 1);
        chk("bs_addr", addr, 164);
        chk("bs_dina", dina, 8'h20);
        chk("bs_cursor", {cursor_y, cursor_x}, {6'd2, 7'd4});

        // Abort a clear part way through
        send(8'h0C);
        n = 0;
        while (!(wea && addr == 13'd2000) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_2000", (wea && addr == 13'd2000) ? 1 : 0, 1);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("abort_wea", wea, 0);
        chk("abort_addr", addr, 0);
        chk("abort_busy", busy, 1);
        run_fill(0, nw, nbad, nlow);
        chk("abort_writes", nw, 4800);
        chk("abort_bad", nbad, 0);
        chk("abort_low", nlow, 4800);

        chk("addr_in_range", oob, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
